// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: SPI transaction controller.
// Deserialises the PICO stream (LSB first) into a command byte
// {write, addr[6:0]}, then sequences either a burst read or a burst write.
//
// Ports:
//   sclk           SPI clock, all logic on posedge
//   rst            asynchronous active-high reset
//   csb            chip select, active-low
//   pico           serial data in, LSB first
//   control_signal readout mux select / current register address
//   msg_flag       one-cycle strobe to load the POCI output shift register
//   wr_data        assembled write byte
//   wr_en          one-hot write strobe, bit k writes address k+1
//   busy           high whenever the sequencer is not idle
//   addr_err       sticky error flag for the current transaction
module spi_txn_sequencer #(
  parameter int NUM_REGS = 59,
  parameter int NUM_RW   = 3
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              csb,
  input  logic              pico,
  output logic [7:0]        control_signal,
  output logic              msg_flag,
  output logic [7:0]        wr_data,
  output logic [NUM_RW-1:0] wr_en,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [7:0] NUM_RW_B   = 8'(NUM_RW);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD,
    WR,
    DISCARD
  } state_e;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        ctrl_q;
  logic [7:0]        wr_data_q;
  logic              msg_q;
  logic              err_q;
  logic              busy_q;
  logic [NUM_RW-1:0] wr_en_q;

  logic [7:0]        byte_d;
  logic [6:0]        addr_d;
  logic              is_wr_d;
  logic              rd_ok_d;
  logic              wr_ok_d;
  logic [NUM_RW-1:0] wr_en_d;
  logic [7:0]        rd_next_d;
  logic [7:0]        wr_next_d;

  // Byte completed by the current edge: the incoming bit lands in the MSB.
  always_comb begin
    byte_d    = {pico, shift_q[7:1]};
    is_wr_d   = byte_d[7];
    addr_d    = byte_d[6:0];
    rd_ok_d   = !is_wr_d && (addr_d != 7'd0) && ({1'b0, addr_d} <= NUM_REGS_B);
    wr_ok_d   = is_wr_d && (addr_d != 7'd0) && ({1'b0, addr_d} <= NUM_RW_B);
    rd_next_d = (ctrl_q == NUM_REGS_B) ? 8'd1 : ctrl_q + 8'd1;
    wr_next_d = (ctrl_q == NUM_RW_B) ? 8'd1 : ctrl_q + 8'd1;
    wr_en_d   = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      wr_en_d[k] = (ctrl_q == 8'(k + 1));
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ctrl_q    <= '0;
      wr_data_q <= '0;
      msg_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= '0;
    end else begin
      // Strobes default low so each pulse lasts exactly one cycle.
      msg_q   <= 1'b0;
      wr_en_q <= '0;
      if (csb) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= CMD;
            bit_cnt_q <= 3'd1;
            busy_q    <= 1'b1;
            shift_q   <= byte_d;
          end
          CMD: begin
            shift_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              err_q <= 1'b0;
              if (rd_ok_d) begin
                ctrl_q  <= {1'b0, addr_d};
                msg_q   <= 1'b1;
                state_q <= RD;
              end else if (wr_ok_d) begin
                ctrl_q  <= {1'b0, addr_d};
                state_q <= WR;
              end else begin
                err_q   <= 1'b1;
                ctrl_q  <= '0;
                state_q <= DISCARD;
              end
            end
          end
          RD: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ctrl_q <= rd_next_d;
              msg_q  <= 1'b1;
            end
          end
          WR: begin
            shift_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_data_q <= byte_d;
              wr_en_q   <= wr_en_d;
              ctrl_q    <= wr_next_d;
            end
          end
          DISCARD: begin
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign control_signal = ctrl_q;
  assign msg_flag       = msg_q;
  assign wr_data        = wr_data_q;
  assign wr_en          = wr_en_q;
  assign busy           = busy_q;
  assign addr_err       = err_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
module tb_spi_txn_sequencer;

  logic       sclk;
  logic       rst;
  logic       csb;
  logic       pico;
  logic [7:0] control_signal;
  logic       msg_flag;
  logic [7:0] wr_data;
  logic [2:0] wr_en;
  logic       busy;
  logic       addr_err;

  int tests;
  int fails;

  spi_txn_sequencer #(
    .NUM_REGS(59),
    .NUM_RW  (3)
  ) dut (
    .sclk          (sclk),
    .rst           (rst),
    .csb           (csb),
    .pico          (pico),
    .control_signal(control_signal),
    .msg_flag      (msg_flag),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .busy          (busy),
    .addr_err      (addr_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, take one edge, settle 1 time unit past the edge.
  task automatic send_bit(input logic b);
    pico = b;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic idle_tick();
    csb  = 1'b1;
    pico = 1'b0;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    csb   = 1'b0;
    pico  = 1'b0;
    #2 rst = 1'b1;

    // Reset held with csb low and toggling pico.
    for (int i = 0; i < 4; i++) begin
      send_bit(~pico);
      check("rst_busy", busy, 0);
      check("rst_msg", msg_flag, 0);
    end
    check("rst_ctrl", control_signal, 0);
    check("rst_wrdata", wr_data, 0);
    check("rst_wren", wr_en, 0);
    check("rst_err", addr_err, 0);
    csb = 1'b1;
    rst = 1'b0;
    idle_tick();
    idle_tick();
    check("post_rst_idle", busy, 0);

    // Write 0x82 (addr 2) then data 0x5A.
    csb = 1'b0;
    send_bits(8'h82, 8);
    check("wr_cmd_busy", busy, 1);
    check("wr_cmd_ctrl", control_signal, 2);
    check("wr_cmd_err", addr_err, 0);
    check("wr_cmd_msg", msg_flag, 0);
    send_bits(8'h5A, 7);
    check("wr_data_pre_wren", wr_en, 0);
    send_bit(1'b0);
    check("wr_data", wr_data, 8'h5A);
    check("wr_en", wr_en, 3'b010);
    check("wr_ctrl_inc", control_signal, 3);
    check("wr_msg_quiet", msg_flag, 0);
    idle_tick();
    check("wr_en_one_cycle", wr_en, 0);
    check("wr_data_hold", wr_data, 8'h5A);
    check("wr_idle_busy", busy, 0);
    check("wr_ctrl_hold", control_signal, 3);

    // Burst read from 58 with wrap at 59 -> 1.
    csb = 1'b0;
    send_bits(8'h3A, 8);
    check("rd_ctrl_58", control_signal, 58);
    check("rd_msg_1", msg_flag, 1);
    for (int e = 9; e <= 24; e++) begin
      send_bit(1'b1);
      check("rd_msg_seq", msg_flag, (e == 16 || e == 24) ? 1 : 0);
      check("rd_wren_quiet", wr_en, 0);
      if (e == 16) check("rd_ctrl_59", control_signal, 59);
      if (e == 24) check("rd_ctrl_wrap", control_signal, 1);
    end
    idle_tick();
    check("rd_end_msg", msg_flag, 0);
    check("rd_end_busy", busy, 0);

    // Command 0x00: address zero.
    csb = 1'b0;
    send_bits(8'h00, 8);
    check("err0_flag", addr_err, 1);
    check("err0_ctrl", control_signal, 0);
    check("err0_msg", msg_flag, 0);
    check("err0_busy", busy, 1);
    idle_tick();
    check("err0_sticky", addr_err, 1);

    // Command 0x3C: read address 60, out of range.
    csb = 1'b0;
    send_bits(8'h3C, 8);
    check("err60_flag", addr_err, 1);
    check("err60_msg", msg_flag, 0);
    idle_tick();

    // Command 0x84: write to read-only address 4, data byte must be dropped.
    csb = 1'b0;
    send_bits(8'h84, 8);
    check("err84_flag", addr_err, 1);
    for (int i = 0; i < 9; i++) begin
      send_bit(1'b1);
      check("err84_no_wren", wr_en, 0);
      check("err84_no_msg", msg_flag, 0);
    end
    check("err84_wrdata_hold", wr_data, 8'h5A);
    idle_tick();

    // Valid read clears the error.
    csb = 1'b0;
    send_bits(8'h05, 8);
    check("clr_err", addr_err, 0);
    check("clr_ctrl", control_signal, 5);
    check("clr_msg", msg_flag, 1);
    idle_tick();

    // Abort a write after 5 data bits.
    csb = 1'b0;
    send_bits(8'h81, 8);
    check("abort_ctrl", control_signal, 1);
    send_bits(8'hFF, 5);
    idle_tick();
    check("abort_busy", busy, 0);
    check("abort_wren", wr_en, 0);
    idle_tick();
    check("abort_wren2", wr_en, 0);
    check("abort_wrdata", wr_data, 8'h5A);

    // Fresh write to addr 3 parses from bit 0 and wraps 3 -> 1.
    csb = 1'b0;
    send_bits(8'h83, 8);
    check("w3_ctrl", control_signal, 3);
    send_bits(8'hC3, 8);
    check("w3_data", wr_data, 8'hC3);
    check("w3_wren", wr_en, 3'b100);
    check("w3_wrap", control_signal, 1);
    idle_tick();

    // Reset in the middle of the second read byte.
    csb = 1'b0;
    send_bits(8'h10, 8);
    check("rr_ctrl16", control_signal, 16);
    send_bits(8'h00, 8);
    check("rr_ctrl17", control_signal, 17);
    check("rr_msg2", msg_flag, 1);
    send_bits(8'h00, 3);
    rst = 1'b1;
    #1;
    check("rr_async_msg", msg_flag, 0);
    check("rr_async_ctrl", control_signal, 0);
    check("rr_async_busy", busy, 0);
    idle_tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_tick();
      check("rr_no_pulse", msg_flag, 0);
    end
    check("rr_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
